fifo_wr_sequencer: RTL and testbench

FIFO_WR_SEQUENCER -- requirements
Module: fifo_wr_sequencer

---
 rtl/fifo_seq_pkg.sv | 23 ++
 rtl/fifo_wr_sequencer_lfsr16.sv | 22 ++
 rtl/fifo_wr_sequencer.sv | 121 ++++++++++++
 tb/tb_fifo_wr_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_seq_pkg.sv
// Shared FSM encoding, LFSR taps and default seed for the FIFO write sequencer.
// Used by lfsr16 and fifo_wr_sequencer.
package fifo_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [15:0] DEFAULT_SEED = 16'h0AA1;

    localparam int TAP0 = 15;
    localparam int TAP1 = 13;
    localparam int TAP2 = 12;
    localparam int TAP3 = 10;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3]};
    endfunction

endpackage

// File: rtl/fifo_wr_sequencer_lfsr16.sv
// 16-bit Fibonacci LFSR data source.
// Loads seed on reset or load, steps on adv.
module lfsr16
    import fifo_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        adv,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (!rst || load) begin
            q <= seed;
        end else if (adv) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/fifo_wr_sequencer.sv
// Burst writer feeding LFSR data into a FIFO with programmable gaps.
// Optional stall counter enabled by defining FIFO_SEQ_STALL_CNT_EN.
module fifo_wr_sequencer
    import fifo_seq_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = DEFAULT_SEED,
    parameter int          GAP_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       burst_len,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             full,
    output logic             wr,
    output logic [7:0]       d_out,
    output logic             busy,
    output logic             done,
    output logic [15:0]      wr_count
`ifdef FIFO_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    state_t           state;
    state_t           state_nx;
    logic [8:0]       remaining;
    logic [GAP_W-1:0] gap_lat;
    logic [GAP_W-1:0] gap_cnt;
    logic             load;
    logic             adv;
    logic             accept;
    logic [15:0]      lfsr_q;

    assign accept = (state == S_IDLE) && start;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .seed (LFSR_SEED),
        .adv  (adv),
        .q    (lfsr_q)
    );

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        adv      = 1'b0;
        wr       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_WRITE;
                    load     = 1'b1;
                end
            end
            S_WRITE: begin
                if (!full) begin
                    wr  = 1'b1;
                    adv = 1'b1;
                    if (remaining == 9'd1) begin
                        state_nx = S_DONE;
                    end else if (gap_lat != '0) begin
                        state_nx = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt <= GAP_W'(1)) begin
                    state_nx = S_WRITE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign d_out = wr ? lfsr_q[7:0] : 8'h00;
    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            gap_lat   <= '0;
            gap_cnt   <= '0;
            wr_count  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                // a zero length encodes a full 256-word burst
                remaining <= (burst_len == 8'd0) ? 9'd256 : {1'b0, burst_len};
                gap_lat   <= gap_len;
            end else if (wr) begin
                remaining <= remaining - 9'd1;
            end
            if (wr) begin
                gap_cnt  <= gap_lat;
                wr_count <= wr_count + 16'd1;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

`ifdef FIFO_SEQ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst || accept) begin
            stall_cnt <= '0;
        end else if (state == S_WRITE && full && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_sequencer.sv
// Self-checking bench for fifo_wr_sequencer: scoreboard of expected
// LFSR words and write totals plus directed timing checks.
module tb_fifo_wr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  burst_len;
    logic [3:0]  gap_len;
    logic        full;
    logic        wr;
    logic [7:0]  d_out;
    logic        busy;
    logic        done;
    logic [15:0] wr_count;
`ifdef FIFO_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    int         model_cnt = 0;

    logic       wr_log   [300];
    logic [7:0] d_log    [300];
    logic       done_log [300];
    logic       busy_log [300];

    always #5 clk = ~clk;

    fifo_wr_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .burst_len (burst_len),
        .gap_len   (gap_len),
        .full      (full),
        .wr        (wr),
        .d_out     (d_out),
        .busy      (busy),
        .done      (done),
        .wr_count  (wr_count)
`ifdef FIFO_SEQ_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic push_burst(input logic [7:0] bl);
        logic [15:0] s;
        int n;
        s = 16'h0AA1;
        n = (bl == 8'd0) ? 256 : int'(bl);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(s[7:0]);
            s = step(s);
        end
    endtask

    // scoreboard: data order, zero data when idle, running write total
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            chk("wr_count", {16'h0, wr_count}, model_cnt[31:0] & 32'hFFFF);
            if (wr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", 32'd1, 32'd0);
                end else begin
                    chk("d_out", {24'h0, d_out}, {24'h0, exp_q.pop_front()});
                end
                model_cnt++;
            end else begin
                chk("d_out_idle", {24'h0, d_out}, 32'h0);
            end
        end
    end

    task automatic pulse_start(input logic [7:0] bl, input logic [3:0] gl);
        @(posedge clk);
        #1;
        start     = 1'b1;
        burst_len = bl;
        gap_len   = gl;
        push_burst(bl);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic record(input int n, input logic [31:0] fm,
                          input logic [31:0] sm);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            full  = (i < 32) ? fm[i] : 1'b0;
            start = (i < 32) ? sm[i] : 1'b0;
            @(negedge clk);
            wr_log[i]   = wr;
            d_log[i]    = d_out;
            done_log[i] = done;
            busy_log[i] = busy;
        end
        @(posedge clk);
        #1;
        full  = 1'b0;
        start = 1'b0;
    endtask

    int nw;
    int nd;
    int dpos;

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        burst_len = 8'd0;
        gap_len   = 4'd0;
        full      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_wr", {31'h0, wr}, 32'd0);
        chk("rst_dout", {24'h0, d_out}, 32'd0);
        chk("rst_count", {16'h0, wr_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // burst of 3, no gap
        pulse_start(8'd3, 4'd0);
        record(5, 32'h0, 32'h0);
        chk("b3_wr0", {31'h0, wr_log[0]}, 32'd1);
        chk("b3_wr1", {31'h0, wr_log[1]}, 32'd1);
        chk("b3_wr2", {31'h0, wr_log[2]}, 32'd1);
        chk("b3_d0", {24'h0, d_log[0]}, 32'hA1);
        chk("b3_d1", {24'h0, d_log[1]}, 32'h42);
        chk("b3_d2", {24'h0, d_log[2]}, 32'h84);
        chk("b3_wr3", {31'h0, wr_log[3]}, 32'd0);
        chk("b3_done3", {31'h0, done_log[3]}, 32'd1);
        chk("b3_done4", {31'h0, done_log[4]}, 32'd0);
        chk("b3_busy4", {31'h0, busy_log[4]}, 32'd0);
        chk("b3_count", {16'h0, wr_count}, 32'd3);

        // burst of 2 with gap 2
        pulse_start(8'd2, 4'd2);
        record(6, 32'h0, 32'h0);
        chk("g2_pat", {28'h0, wr_log[0], wr_log[1], wr_log[2], wr_log[3]},
            32'b1001);
        chk("g2_done", {31'h0, done_log[4]}, 32'd1);
        chk("g2_d3", {24'h0, d_log[3]}, 32'h42);
        chk("g2_idle", {31'h0, busy_log[5]}, 32'd0);

        // full stalls 4 cycles after the first write
        pulse_start(8'd3, 4'd0);
        record(9, 32'b11110, 32'h0);
        chk("st_wr0", {31'h0, wr_log[0]}, 32'd1);
        chk("st_gap", {28'h0, wr_log[1], wr_log[2], wr_log[3], wr_log[4]},
            32'd0);
        chk("st_wr5", {31'h0, wr_log[5]}, 32'd1);
        chk("st_d5", {24'h0, d_log[5]}, 32'h42);
        chk("st_d6", {24'h0, d_log[6]}, 32'h84);
        chk("st_done7", {31'h0, done_log[7]}, 32'd1);
`ifdef FIFO_SEQ_STALL_CNT_EN
        chk("stall_cnt", {16'h0, stall_cnt}, 32'd4);
`endif

        // start while busy must not restart or resize the burst
        pulse_start(8'd4, 4'd1);
        burst_len = 8'd1;
        gap_len   = 4'd0;
        record(10, 32'h0, 32'b0110);
        nw = 0;
        for (int i = 0; i < 10; i++) nw += int'(wr_log[i]);
        chk("busy_start_writes", nw[31:0], 32'd4);
        chk("busy_start_done7", {31'h0, done_log[7]}, 32'd1);
        chk("busy_start_pat", {29'h0, wr_log[0], wr_log[1], wr_log[2]},
            32'b101);

        // burst_len 0 means 256
        pulse_start(8'd0, 4'd0);
        record(260, 32'h0, 32'h0);
        nw = 0;
        nd = 0;
        dpos = -1;
        for (int i = 0; i < 260; i++) begin
            nw += int'(wr_log[i]);
            if (done_log[i]) begin
                nd++;
                dpos = i;
            end
        end
        chk("b256_writes", nw[31:0], 32'd256);
        chk("b256_done_cnt", nd[31:0], 32'd1);
        chk("b256_done_pos", dpos[31:0], 32'd256);
        chk("b256_total", {16'h0, wr_count}, 32'd268);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        // reset during the 10th write aborts the burst
        pulse_start(8'd0, 4'd0);
        record(9, 32'h0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_wr10", {31'h0, wr}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        nw = 0;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            nw += int'(wr);
            nd += int'(done);
            chk("abort_busy", {31'h0, busy}, 32'd0);
        end
        chk("abort_no_wr", nw[31:0], 32'd0);
        chk("abort_no_done", nd[31:0], 32'd0);
        chk("abort_count", {16'h0, wr_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
